// File: rtl/clock_divider_ctrl.sv
// Purpose : round-robin arbiter that reprograms a shared clock_divider (scale + active-low reset pulse) for NREQ requesters.
// Latency : grant in cycle t, div_nrst low t+1..t+HOLD_CYC, one-cycle req_ack in cycle t+HOLD_CYC+SETTLE_CYC+1.
// Backpr. : requesters hold i_req_valid/i_req_scale until ack; no new grant while busy, a dropped valid still completes.
//
// Ports:
//   i_clk_in     system clock, rising edge
//   i_rst        synchronous active-high reset; aborts any transaction and restarts the init sequence
//   i_req_valid  per-requester request
//   i_req_scale  requester i scale at [i*WIDTH +: WIDTH], sampled only at grant
//   o_req_ack    one-hot single-cycle completion pulse
//   o_busy       high whenever the controller is not idle
//   o_owner      current (or last) granted requester
//   o_div_scale  scale driven to the divider, held between transactions
//   o_div_nrst   active-low reset driven to the divider
module clock_divider_ctrl #(
  parameter int WIDTH       = 8,
  parameter int NREQ        = 4,
  parameter int HOLD_CYC    = 2,
  parameter int SETTLE_CYC  = 4,
  parameter int RESET_SCALE = 1,
  localparam int OW         = $clog2(NREQ)
) (
  input  logic                  i_clk_in,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_scale,
  output logic [NREQ-1:0]       o_req_ack,
  output logic                  o_busy,
  output logic [OW-1:0]         o_owner,
  output logic [WIDTH-1:0]      o_div_scale,
  output logic                  o_div_nrst
);

  localparam int CMAX = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_SETTLE,
    S_ACK
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_init;
  logic [OW-1:0]    r_rr_ptr;
  logic [OW-1:0]    r_owner;
  logic [WIDTH-1:0] r_div_scale;
  logic             r_div_nrst;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_init_nxt;
  logic [OW-1:0]    w_rr_ptr_nxt;
  logic [OW-1:0]    w_owner_nxt;
  logic [WIDTH-1:0] w_div_scale_nxt;
  logic             w_div_nrst_nxt;

  logic             w_found;
  logic [OW-1:0]    w_winner;
  logic [OW:0]      w_idx;
  logic [WIDTH-1:0] w_win_scale;
  logic [NREQ-1:0]  w_ack;

  // Round-robin search starting at r_rr_ptr. The index is one bit wider so
  // r_rr_ptr + k cannot overflow before the wrap subtraction.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (OW+1)'(k);
      if (w_idx >= (OW+1)'(NREQ)) begin
        w_idx = w_idx - (OW+1)'(NREQ);
      end
      if (!w_found && i_req_valid[w_idx[OW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[OW-1:0];
      end
    end
  end

  always_comb begin
    w_win_scale = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_winner == OW'(j)) begin
        w_win_scale = i_req_scale[j*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state logic. r_init marks the post-reset sequence, which reloads
  // RESET_SCALE into the divider and returns to idle without an ack.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_init_nxt      = r_init;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_owner_nxt     = r_owner;
    w_div_scale_nxt = r_div_scale;
    w_div_nrst_nxt  = r_div_nrst;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner_nxt     = w_winner;
          w_div_scale_nxt = w_win_scale;
          w_div_nrst_nxt  = 1'b0;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == CW'(HOLD_CYC - 1)) begin
          w_div_nrst_nxt = 1'b1;
          w_cnt_nxt      = '0;
          w_state_nxt    = S_SETTLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_SETTLE: begin
        if (r_cnt == CW'(SETTLE_CYC - 1)) begin
          w_cnt_nxt = '0;
          if (r_init) begin
            w_init_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_ACK;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_ACK: begin
        w_rr_ptr_nxt = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + OW'(1);
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_state     <= S_HOLD;
      r_cnt       <= '0;
      r_init      <= 1'b1;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_div_scale <= WIDTH'(RESET_SCALE);
      r_div_nrst  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_init      <= w_init_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_div_scale <= w_div_scale_nxt;
      r_div_nrst  <= w_div_nrst_nxt;
    end
  end

  always_comb begin
    w_ack = '0;
    if (r_state == S_ACK) begin
      w_ack[r_owner] = 1'b1;
    end
  end

  assign o_req_ack   = w_ack;
  assign o_busy      = (r_state != S_IDLE);
  assign o_owner     = r_owner;
  assign o_div_scale = r_div_scale;
  assign o_div_nrst  = r_div_nrst;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Purpose : self-checking bench for clock_divider_ctrl against a transaction-timing reference model.
// Latency : model predicts outputs from the grant cycle: nrst low for HOLD cycles, ack HOLD+SETTLE+1 cycles after grant.
// Backpr. : requester agents hold valid until the ack edge, with random drops and late re-requests.
module tb_clock_divider_ctrl;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int HOLD  = 2;
  localparam int SETL  = 4;
  localparam int RSCL  = 1;
  localparam int TOT   = HOLD + SETL + 1;

  logic                  clk;
  logic                  i_rst;
  logic [NREQ-1:0]       i_req_valid;
  logic [NREQ*WIDTH-1:0] i_req_scale;
  logic [NREQ-1:0]       o_req_ack;
  logic                  o_busy;
  logic [1:0]            o_owner;
  logic [WIDTH-1:0]      o_div_scale;
  logic                  o_div_nrst;

  clock_divider_ctrl #(
    .WIDTH(WIDTH), .NREQ(NREQ), .HOLD_CYC(HOLD), .SETTLE_CYC(SETL), .RESET_SCALE(RSCL)
  ) dut (
    .i_clk_in   (clk),
    .i_rst      (i_rst),
    .i_req_valid(i_req_valid),
    .i_req_scale(i_req_scale),
    .o_req_ack  (o_req_ack),
    .o_busy     (o_busy),
    .o_owner    (o_owner),
    .o_div_scale(o_div_scale),
    .o_div_nrst (o_div_nrst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Requester agents
  bit             pend [NREQ];
  logic [WIDTH-1:0] scl [NREQ];

  // Reference model: everything is derived from the cycle of the last
  // grant (or reset) and whether that sequence is the init one.
  int cyc     = 0;
  int m_t     = 0;
  bit m_init  = 1'b1;
  int m_owner = 0;
  int m_ptr   = 0;
  logic [WIDTH-1:0] m_scale = WIDTH'(RSCL);

  function automatic bit m_idle();
    int p;
    p = cyc - m_t;
    return m_init ? (p >= TOT) : (p >= TOT + 1);
  endfunction

  function automatic bit exp_busy();
    int p;
    p = cyc - m_t;
    return (p >= 1) && (m_init ? (p <= TOT - 1) : (p <= TOT));
  endfunction

  function automatic bit exp_nrst();
    int p;
    p = cyc - m_t;
    return !((p >= 1) && (p <= HOLD));
  endfunction

  function automatic logic [NREQ-1:0] exp_ack();
    logic [NREQ-1:0] a;
    a = '0;
    if (!m_init && (cyc - m_t) == TOT) a[m_owner] = 1'b1;
    return a;
  endfunction

  // Drive this cycle's inputs, apply the model's update for the closing
  // edge, then move to #1 after that edge.
  task automatic advance(input bit rst_v);
    int p;
    int w;
    i_rst = rst_v;
    for (int i = 0; i < NREQ; i++) begin
      i_req_valid[i] = pend[i];
      i_req_scale[i*WIDTH +: WIDTH] = scl[i];
    end
    p = cyc - m_t;
    if (rst_v) begin
      m_t = cyc; m_init = 1'b1; m_owner = 0; m_ptr = 0; m_scale = WIDTH'(RSCL);
    end else if (!m_init && p == TOT) begin
      m_ptr = (m_owner + 1) % NREQ;
      pend[m_owner] = 1'b0;
    end else if (m_idle()) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && pend[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      if (w >= 0) begin
        m_t = cyc; m_init = 1'b0; m_owner = w; m_scale = scl[w];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int i = 0; i < 12 && !m_idle(); i++) advance(1'b0);
  endtask

  task automatic test_reset();
    advance(1'b1);
    for (int r = 0; r < 2; r++) begin
      n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL rst_busy r=%0d got=%0b want=1", r, o_busy); end
      n_vec++; if (o_div_nrst !== 1'b0) begin n_err++; $display("FAIL rst_nrst r=%0d got=%0b want=0", r, o_div_nrst); end
      advance(1'b1);
    end
    for (int k = 1; k <= 8; k++) begin
      n_vec++; if (o_div_nrst !== (k > 2)) begin n_err++; $display("FAIL init_nrst k=%0d got=%0b want=%0b", k, o_div_nrst, k > 2); end
      n_vec++; if (o_busy !== (k <= 6)) begin n_err++; $display("FAIL init_busy k=%0d got=%0b want=%0b", k, o_busy, k <= 6); end
      n_vec++; if (o_req_ack !== 4'b0000) begin n_err++; $display("FAIL init_ack k=%0d got=%0h want=0", k, o_req_ack); end
      n_vec++; if (o_div_scale !== 8'd1) begin n_err++; $display("FAIL init_scale k=%0d got=%0d want=1", k, o_div_scale); end
      n_vec++; if (o_owner !== 2'd0) begin n_err++; $display("FAIL init_owner k=%0d got=%0d want=0", k, o_owner); end
      advance(1'b0);
    end
  endtask

  task automatic test_single();
    pend[2] = 1'b1; scl[2] = 8'd10;
    for (int k = 0; k <= 9; k++) begin
      n_vec++; if (o_div_scale !== ((k >= 1) ? 8'd10 : 8'd1)) begin n_err++; $display("FAIL single_scale k=%0d got=%0d", k, o_div_scale); end
      n_vec++; if (o_div_nrst !== !(k >= 1 && k <= 2)) begin n_err++; $display("FAIL single_nrst k=%0d got=%0b", k, o_div_nrst); end
      n_vec++; if (o_req_ack !== ((k == 7) ? 4'b0100 : 4'b0000)) begin n_err++; $display("FAIL single_ack k=%0d got=%0h", k, o_req_ack); end
      n_vec++; if (o_busy !== (k >= 1 && k <= 7)) begin n_err++; $display("FAIL single_busy k=%0d got=%0b", k, o_busy); end
      n_vec++; if (o_owner !== ((k >= 1) ? 2'd2 : 2'd0)) begin n_err++; $display("FAIL single_owner k=%0d got=%0d", k, o_owner); end
      advance(1'b0);
    end
  endtask

  task automatic test_reset_mid();
    pend[1] = 1'b1; scl[1] = 8'd77;
    advance(1'b0);
    n_vec++; if (o_owner !== 2'd1) begin n_err++; $display("FAIL mid_owner got=%0d want=1", o_owner); end
    n_vec++; if (o_div_scale !== 8'd77) begin n_err++; $display("FAIL mid_scale got=%0d want=77", o_div_scale); end
    pend[1] = 1'b0;
    advance(1'b1);
    for (int j = 1; j <= 10; j++) begin
      n_vec++; if (o_req_ack !== 4'b0000) begin n_err++; $display("FAIL mid_ack j=%0d got=%0h want=0", j, o_req_ack); end
      n_vec++; if (o_div_scale !== 8'd1) begin n_err++; $display("FAIL mid_rscale j=%0d got=%0d want=1", j, o_div_scale); end
      n_vec++; if (o_div_nrst !== (j > 2)) begin n_err++; $display("FAIL mid_nrst j=%0d got=%0b", j, o_div_nrst); end
      n_vec++; if (o_busy !== (j <= 6)) begin n_err++; $display("FAIL mid_busy j=%0d got=%0b", j, o_busy); end
      advance(1'b0);
    end
  endtask

  task automatic test_round_robin();
    int n_ack;
    int last;
    n_ack = 0; last = -1;
    for (int i = 0; i < NREQ; i++) scl[i] = WIDTH'($urandom_range(255));
    for (int k = 0; k < 50; k++) begin
      n_vec++; if (o_div_scale !== m_scale) begin n_err++; $display("FAIL rr_scale k=%0d got=%0d want=%0d", k, o_div_scale, m_scale); end
      if (o_req_ack !== 4'b0000) begin
        n_vec++; if (o_req_ack !== (4'b0001 << (n_ack % 4))) begin n_err++; $display("FAIL rr_order n=%0d got=%0h want=%0h", n_ack, o_req_ack, 4'b0001 << (n_ack % 4)); end
        n_vec++; if ((last < 0 ? k : k - last) !== (last < 0 ? 7 : 8)) begin n_err++; $display("FAIL rr_gap n=%0d got=%0d", n_ack, last < 0 ? k : k - last); end
        last = k;
        n_ack++;
      end
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b1;
      advance(1'b0);
    end
    n_vec++; if (n_ack < 5) begin n_err++; $display("FAIL rr_count got=%0d want>=5", n_ack); end
    drain();
  endtask

  task automatic test_drop();
    int w;
    int other;
    pend[0] = 1'b1; scl[0] = 8'h33;
    pend[3] = 1'b1; scl[3] = 8'h44;
    w = pend[m_ptr % NREQ] ? m_ptr : ((m_ptr == 0) ? 0 : 3);
    if (m_ptr == 1 || m_ptr == 2) w = 3;
    other = (w == 0) ? 3 : 0;
    for (int k = 0; k <= 16; k++) begin
      n_vec++; if (o_req_ack !== exp_ack()) begin n_err++; $display("FAIL drop_ack k=%0d got=%0h want=%0h", k, o_req_ack, exp_ack()); end
      n_vec++; if (o_busy !== exp_busy()) begin n_err++; $display("FAIL drop_busy k=%0d got=%0b want=%0b", k, o_busy, exp_busy()); end
      if (k == 7) begin
        n_vec++; if (o_req_ack !== (4'b0001 << w)) begin n_err++; $display("FAIL drop_ack7 got=%0h want=%0h", o_req_ack, 4'b0001 << w); end
      end
      if (k == 9) begin
        n_vec++; if (o_owner !== 2'(other)) begin n_err++; $display("FAIL drop_next got=%0d want=%0d", o_owner, other); end
      end
      if (k == 15) begin
        n_vec++; if (o_req_ack !== (4'b0001 << other)) begin n_err++; $display("FAIL drop_ack15 got=%0h want=%0h", o_req_ack, 4'b0001 << other); end
      end
      if (k == 4) pend[w] = 1'b0;
      advance(1'b0);
    end
    drain();
  endtask

  task automatic test_scale_zero();
    pend[1] = 1'b1; scl[1] = 8'd0;
    for (int k = 0; k <= 8; k++) begin
      if (k >= 1) begin
        n_vec++; if (o_div_scale !== 8'd0) begin n_err++; $display("FAIL zero_scale k=%0d got=%0d want=0", k, o_div_scale); end
      end
      n_vec++; if (o_div_nrst !== !(k >= 1 && k <= 2)) begin n_err++; $display("FAIL zero_nrst k=%0d got=%0b", k, o_div_nrst); end
      n_vec++; if (o_req_ack !== ((k == 7) ? 4'b0010 : 4'b0000)) begin n_err++; $display("FAIL zero_ack k=%0d got=%0h", k, o_req_ack); end
      advance(1'b0);
    end
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      n_vec++; if (o_busy !== exp_busy()) begin n_err++; $display("FAIL rnd_busy cyc=%0d got=%0b want=%0b", cyc, o_busy, exp_busy()); end
      n_vec++; if (o_div_nrst !== exp_nrst()) begin n_err++; $display("FAIL rnd_nrst cyc=%0d got=%0b want=%0b", cyc, o_div_nrst, exp_nrst()); end
      n_vec++; if (o_req_ack !== exp_ack()) begin n_err++; $display("FAIL rnd_ack cyc=%0d got=%0h want=%0h", cyc, o_req_ack, exp_ack()); end
      n_vec++; if (o_div_scale !== m_scale) begin n_err++; $display("FAIL rnd_scale cyc=%0d got=%0d want=%0d", cyc, o_div_scale, m_scale); end
      n_vec++; if (o_owner !== 2'(m_owner)) begin n_err++; $display("FAIL rnd_owner cyc=%0d got=%0d want=%0d", cyc, o_owner, m_owner); end
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(7) == 0) begin
          pend[i] = 1'b1;
          scl[i]  = ($urandom_range(7) == 0) ? 8'd0 : WIDTH'($urandom_range(255));
        end else if (pend[i] && $urandom_range(40) == 0) begin
          pend[i] = 1'b0;
        end else if ($urandom_range(15) == 0) begin
          scl[i] = WIDTH'($urandom_range(255));
        end
      end
      advance($urandom_range(250) == 0);
    end
  endtask

  initial begin
    i_rst = 1'b1;
    i_req_valid = '0;
    i_req_scale = '0;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; scl[i] = '0; end
    test_reset();
    test_single();
    test_reset_mid();
    test_round_robin();
    test_drop();
    test_scale_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
